// File: rtl/serial_rx_sampler.sv
// UART-style receive front end: synchronises rx, frames start/data/stop, strobes each data bit.
// Optional even-parity bit enabled by defining SERIAL_RX_PARITY_EN.
module serial_rx_sampler #(
  parameter int bit_period = 434,
  parameter int n_data     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic bit_out,
  output logic bit_en,
  output logic busy,
  output logic frame_done,
  output logic frame_err,
  output logic parity_err
);

  localparam int CW = $clog2(bit_period);
  localparam int IW = $clog2(n_data + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(bit_period / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(bit_period - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(n_data - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t          state;
  logic            sync1;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
`ifdef SERIAL_RX_PARITY_EN
  logic            par;
`endif

  // Synchroniser presets to 1 so reset looks like an idle line, not a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
`ifdef SERIAL_RX_PARITY_EN
      par        <= 1'b0;
`endif
      bit_out    <= 1'b0;
      bit_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      sync1      <= rx;
      rx_s       <= sync1;
      bit_en     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF_LOAD;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state <= DATA;
              cnt   <= FULL_LOAD;
              idx   <= '0;
`ifdef SERIAL_RX_PARITY_EN
              par   <= 1'b0;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            bit_out <= rx_s;
            bit_en  <= 1'b1;
            cnt     <= FULL_LOAD;
`ifdef SERIAL_RX_PARITY_EN
            par     <= par ^ rx_s;
`endif
            if (idx == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (cnt == '0) begin
            par   <= par ^ rx_s;
            cnt   <= FULL_LOAD;
            state <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == '0) begin
            frame_done <= 1'b1;
            frame_err  <= ~rx_s;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= par;
`endif
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Line held low past the stop bit: wait for idle before arming start detection
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_sampler.sv
// Directed bench for serial_rx_sampler (bit_period 16, n_data 8) with a modelled w=8 shift register.
module tb_serial_rx_sampler;

  localparam int BP = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam int NB = 9;
  localparam logic PAR_EXP = 1'b1;
`else
  localparam int NB = 8;
  localparam logic PAR_EXP = 1'b0;
`endif
  localparam int FIRST_LAT = 27;
  localparam int DONE_LAT  = 11 + BP * (NB + 1);
  localparam int FRAME_LEN = BP * (NB + 2);

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic bit_out, bit_en, busy, frame_done, frame_err, parity_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int busy_cnt = 0;
  int n_err = 0;
  int n_perr = 0;
  logic [7:0] sr = 8'h00;
  int bit_times[$];
  int done_times[$];
  logic [7:0] words[$];

  serial_rx_sampler #(.bit_period(BP), .n_data(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .bit_out(bit_out), .bit_en(bit_en),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream shift register model and event log
  always @(negedge clk) begin
    if (bit_en) begin
      sr = {bit_out, sr[7:1]};
      bit_times.push_back(cyc);
    end
    if (frame_done) begin
      words.push_back(sr);
      done_times.push_back(cyc);
      n_err  = n_err + int'(frame_err);
      n_perr = n_perr + int'(parity_err);
    end
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] fb(input logic [7:0] d, input logic bad);
    return {(^d) ^ bad, d};
  endfunction

  task automatic send(input logic [8:0] bits, input logic stop);
    start_cyc = cyc;
    line(1'b0, BP);
    for (int i = 0; i < NB; i++) line(bits[i], BP);
    line(stop, BP);
  endtask

  function automatic int bt(input int i);
    return (i < bit_times.size()) ? bit_times[i] : -1000;
  endfunction

  function automatic int dt(input int i);
    return (i < done_times.size()) ? done_times[i] : -1000;
  endfunction

  function automatic logic [7:0] wd(input int i);
    return (i < words.size()) ? words[i] : 8'hxx;
  endfunction

  int b0, d0, w0, e0, p0, bc0;
  int s1;

  initial begin
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {26'd0, bit_out, bit_en, busy, frame_done, frame_err, parity_err}, 32'd0);
    rst_n = 1'b1;
    line(1'b1, 5);

    // 1: single clean frame 0xA5
    b0 = bit_times.size(); d0 = done_times.size(); w0 = words.size(); e0 = n_err;
    send(fb(8'hA5, 1'b0), 1'b1);
    line(1'b1, 8);
    chk("a5_bit_count", bit_times.size() - b0, 8);
    chk("a5_done_count", done_times.size() - d0, 1);
    chk("a5_word", wd(w0), 8'hA5);
    chk("a5_frame_err", n_err - e0, 0);
    chk("a5_first_strobe_lat", bt(b0) - start_cyc, FIRST_LAT);
    chk("a5_bit_spacing", bt(b0 + 1) - bt(b0), BP);
    chk("a5_span", bt(b0 + 7) - bt(b0), 7 * BP);
    chk("a5_done_lat", dt(d0) - start_cyc, DONE_LAT);
    chk("a5_busy_idle", busy, 1'b0);

    // 2: false start
    b0 = bit_times.size(); d0 = done_times.size(); bc0 = busy_cnt;
    line(1'b0, 4);
    line(1'b1, 40);
    chk("fs_bit_count", bit_times.size() - b0, 0);
    chk("fs_done_count", done_times.size() - d0, 0);
    chk("fs_busy_cycles", busy_cnt - bc0, BP / 2);
    chk("fs_busy_idle", busy, 1'b0);

    // 3: stop bit low, long break, then clean 0x12
    b0 = bit_times.size(); d0 = done_times.size(); w0 = words.size(); e0 = n_err;
    send(fb(8'h3C, 1'b0), 1'b0);
    line(1'b0, 40);
    chk("brk_done_count", done_times.size() - d0, 1);
    chk("brk_frame_err", n_err - e0, 1);
    chk("brk_word", wd(w0), 8'h3C);
    chk("brk_busy_held", busy, 1'b1);
    line(1'b1, 6);
    chk("brk_busy_released", busy, 1'b0);
    chk("brk_no_extra_frame", done_times.size() - d0, 1);
    send(fb(8'h12, 1'b0), 1'b1);
    line(1'b1, 8);
    chk("brk_next_done", done_times.size() - d0, 2);
    chk("brk_next_word", wd(w0 + 1), 8'h12);
    chk("brk_next_err", n_err - e0, 1);
    chk("brk_bit_count", bit_times.size() - b0, 16);

    // 4: reset during data bit 3 of 0xFF
    d0 = done_times.size(); w0 = words.size(); e0 = n_err;
    line(1'b0, BP);
    line(1'b1, 3 * BP + BP / 2);
    chk("rst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {26'd0, bit_out, bit_en, busy, frame_done, frame_err, parity_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    line(1'b1, 5);
    chk("rst_no_done", done_times.size() - d0, 0);
    b0 = bit_times.size();
    send(fb(8'h81, 1'b0), 1'b1);
    line(1'b1, 8);
    chk("rst_next_bits", bit_times.size() - b0, 8);
    chk("rst_next_done", done_times.size() - d0, 1);
    chk("rst_next_word", wd(w0), 8'h81);
    chk("rst_next_err", n_err - e0, 0);

    // 5: back-to-back 0x00, 0xFF
    b0 = bit_times.size(); d0 = done_times.size(); w0 = words.size(); e0 = n_err;
    send(fb(8'h00, 1'b0), 1'b1);
    s1 = start_cyc;
    send(fb(8'hFF, 1'b0), 1'b1);
    line(1'b1, 8);
    chk("b2b_done_count", done_times.size() - d0, 2);
    chk("b2b_bit_count", bit_times.size() - b0, 16);
    chk("b2b_word0", wd(w0), 8'h00);
    chk("b2b_word1", wd(w0 + 1), 8'hFF);
    chk("b2b_frame_err", n_err - e0, 0);
    chk("b2b_done_spacing", dt(d0 + 1) - dt(d0), FRAME_LEN);
    chk("b2b_first_lat", bt(b0) - s1, FIRST_LAT);

    // 6: 0x07 with correct then inverted parity bit
    b0 = bit_times.size(); d0 = done_times.size(); w0 = words.size(); p0 = n_perr;
    send(fb(8'h07, 1'b0), 1'b1);
    line(1'b1, 8);
    chk("par_good_err", n_perr - p0, 0);
    chk("par_good_word", wd(w0), 8'h07);
    send(fb(8'h07, 1'b1), 1'b1);
    line(1'b1, 8);
    chk("par_bad_err", n_perr - p0, {31'd0, PAR_EXP});
    chk("par_bad_word", wd(w0 + 1), 8'h07);
    chk("par_bit_count", bit_times.size() - b0, 16);
    chk("par_done_count", done_times.size() - d0, 2);
    chk("par_total_errs", n_perr, {31'd0, PAR_EXP});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
